apb2lb_tmo: RTL and testbench

Parametrised APB-to-local-bus bridge, the successor of the fixed-width `apb2lb`. Sits between an APB master and a generated `regs` register map. Adds parametric address/data width, a bounded wait on `wready`/`rvalid` with a timeout that completes the APB transfer with `pslverr`, and rejection of misaligned addresses before any local-bus strobe is issued.

---
 rtl/apb2lb_tmo_pkg.sv | 21 ++
 rtl/apb2lb_tmo_if.sv | 64 ++++++
 rtl/apb2lb_tmo_lb_timeout.sv | 47 ++++
 rtl/apb2lb_tmo.sv | 145 ++++++++++++++
 tb/tb_apb2lb_tmo.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb2lb_tmo_pkg.sv
// Shared types and helpers for the APB-to-local-bus bridge with response timeout.
package apb2lb_pkg;

    // Bridge FSM: accept a setup phase, strobe the local bus, wait, then complete.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } apb2lb_state_e;

    // True when a byte address is aligned to a data word of strb_w bytes.
    // strb_w is a power of two (1, 2, 4 or 8), so the low log2(strb_w) bits
    // must all be zero.
    function automatic logic lb_aligned(input logic [63:0] addr, input int unsigned strb_w);
        logic [63:0] mask;
        mask = 64'(strb_w) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/apb2lb_tmo_if.sv
// Bus bundles for the bridge: the APB side (bridge is the slave) and the
// local-bus side toward the register map (bridge is the master).
//
// Handshake rules:
//   APB:  a transfer starts with a setup cycle (psel=1, penable=0), followed by
//         access cycles (psel=1, penable=1) until pready=1 for exactly one cycle.
//         prdata and pslverr are meaningful only in the pready cycle.
//   LB:   wen/ren are one-cycle strobes carrying waddr/wdata/wstrb or raddr.
//         The slave answers with wready (write) or rvalid+rdata (read) in the
//         strobe cycle or any later cycle; the address/data stay stable until
//         the answer arrives or the bridge gives up. Answers arriving while no
//         access is outstanding are ignored.

interface apb2lb_apb_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

interface apb2lb_lb_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wen;
    logic              ren;
    logic              wready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output waddr, raddr, wdata, wstrb, wen, ren,
        input  wready, rvalid, rdata
    );

    modport slave (
        input  waddr, raddr, wdata, wstrb, wen, ren,
        output wready, rvalid, rdata
    );
endinterface

// File: rtl/apb2lb_tmo_lb_timeout.sv
// Saturating wait counter for an outstanding local-bus access.
// expired is raised while enabled once the count has reached TIMEOUT.
// TIMEOUT = 0 means wait forever: no counter is built.
module lb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_tie;
        assign unused_tie = ^{clk, rst, clear, enable};
        assign expired    = 1'b0;
    end else begin : g_cnt
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Next count: clear wins, otherwise count up and hold at the limit.
        always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
                cnt_d = '0;
            end else if (enable && (cnt_q != LIMIT)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Count register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired = enable && (cnt_q == LIMIT);
    end

endmodule

// File: rtl/apb2lb_tmo.sv
// APB-to-local-bus bridge with misalignment rejection and a bounded wait on
// the local-bus response. A stuck slave ends the APB transfer with pslverr.
module apb2lb_tmo
    import apb2lb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    apb2lb_apb_if.slave   apb,
    apb2lb_lb_if.master   lb,
    output logic          tmo,
    output apb2lb_state_e state_o
);

    apb2lb_state_e     state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0] strb_q,    strb_d;
    logic              strobe_q,  strobe_d;
    logic [DATA_W-1:0] prdata_q,  prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              tmo_q,     tmo_d;

    logic in_access;
    logic expired;

    assign in_access = (state_q == ST_WR) || (state_q == ST_RD);

    // The wait counter runs only while a strobe is outstanding and restarts
    // from zero on every entry to WR/RD.
    lb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_access),
        .enable  (in_access),
        .expired (expired)
    );

    // Next-state and next-data logic of the bridge FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        strobe_d  = 1'b0;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        tmo_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    addr_d    = apb.paddr;
                    wdata_d   = apb.pwdata;
                    strb_d    = apb.pstrb;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                    if (!lb_aligned(64'(apb.paddr), STRB_W)) begin
                        // Rejected before any local-bus strobe.
                        state_d   = ST_DONE;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d  = apb.pwrite ? ST_WR : ST_RD;
                        strobe_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // A response in the same cycle the count expires still wins.
                if (lb.wready) begin
                    state_d   = ST_DONE;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                end else if (expired) begin
                    state_d   = ST_DONE;
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    tmo_d     = 1'b1;
                end
            end
            ST_RD: begin
                if (lb.rvalid) begin
                    state_d   = ST_DONE;
                    prdata_d  = lb.rdata;
                    pslverr_d = 1'b0;
                end else if (expired) begin
                    state_d   = ST_DONE;
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    tmo_d     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset aborts any transfer without a pready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            strobe_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            strobe_q  <= strobe_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign lb.waddr    = addr_q;
    assign lb.raddr    = addr_q;
    assign lb.wdata    = wdata_q;
    assign lb.wstrb    = strb_q;
    assign lb.wen      = (state_q == ST_WR) && strobe_q;
    assign lb.ren      = (state_q == ST_RD) && strobe_q;

    assign apb.pready  = (state_q == ST_DONE);
    assign apb.pslverr = pslverr_q && (state_q == ST_DONE);
    assign apb.prdata  = prdata_q;

    assign tmo         = tmo_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_apb2lb_tmo.sv
// Directed bench for apb2lb_tmo: small register-map slave model with
// programmable response delay, APB driver task, single check task.
module tb_apb2lb_tmo;
    import apb2lb_pkg::*;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb2lb_apb_if #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) apb_bus ();
    apb2lb_lb_if  #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) lb_bus ();
    logic          tmo;
    apb2lb_state_e state;

    apb2lb_tmo #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .STRB_W  (SW),
        .TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .apb     (apb_bus),
        .lb      (lb_bus),
        .tmo     (tmo),
        .state_o (state)
    );

    // ---------------- slave model ----------------
    // 0x0: RW data register with byte strobes, 0x4: CNT reading 0x00ffff00,
    // 0x8: constant 0x00001234 (writes ignored).
    logic [31:0] reg0 = 32'h0;
    logic        rsp_en;
    int          rsp_dly;
    logic        late_rvalid;
    logic        pend_w, pend_r;
    int          age;

    assign lb_bus.wready = rsp_en && ((lb_bus.wen && rsp_dly == 0) || (pend_w && age == rsp_dly));
    assign lb_bus.rvalid = late_rvalid ||
                           (rsp_en && ((lb_bus.ren && rsp_dly == 0) || (pend_r && age == rsp_dly)));

    always_comb begin
        lb_bus.rdata = 32'h0;
        case (lb_bus.raddr)
            16'h0000: lb_bus.rdata = reg0;
            16'h0004: lb_bus.rdata = 32'h00ff_ff00;
            16'h0008: lb_bus.rdata = 32'h0000_1234;
            default:  lb_bus.rdata = 32'h0;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_w <= 1'b0;
            pend_r <= 1'b0;
            age    <= 0;
        end else if (lb_bus.wready || lb_bus.rvalid || apb_bus.pready) begin
            pend_w <= 1'b0;
            pend_r <= 1'b0;
            age    <= 0;
        end else if (lb_bus.wen) begin
            pend_w <= 1'b1;
            age    <= 1;
        end else if (lb_bus.ren) begin
            pend_r <= 1'b1;
            age    <= 1;
        end else if (pend_w || pend_r) begin
            age <= age + 1;
        end
    end

    always @(posedge clk) begin
        if (lb_bus.wen && lb_bus.waddr == 16'h0000) begin
            for (int b = 0; b < 4; b++) begin
                if (lb_bus.wstrb[b]) reg0[b*8 +: 8] <= lb_bus.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- event monitors ----------------
    int         wen_cnt = 0, ren_cnt = 0, tmo_cnt = 0, pready_cnt = 0;
    logic [3:0] last_wstrb = 4'hf;
    always @(posedge clk) begin
        if (lb_bus.wen) begin
            wen_cnt++;
            last_wstrb = lb_bus.wstrb;
        end
        if (lb_bus.ren)      ren_cnt++;
        if (tmo)             tmo_cnt++;
        if (apb_bus.pready)  pready_cnt++;
    end

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // lat = number of cycles from the setup cycle to the pready cycle; -1 if none.
    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rd, output logic err,
                            output int lat);
        @(negedge clk);
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = wr;
        apb_bus.paddr   = addr;
        apb_bus.pwdata  = data;
        apb_bus.pstrb   = strb;
        rd  = '0;
        err = 1'b0;
        @(negedge clk);
        apb_bus.penable = 1'b1;
        lat = 1;
        while (!apb_bus.pready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (apb_bus.pready) begin
            rd  = apb_bus.prdata;
            err = apb_bus.pslverr;
        end else begin
            lat = -1;
        end
    endtask

    task automatic apb_idle();
        @(negedge clk);
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pready"},  64'(apb_bus.pready),  64'd0);
        check({tag, "_pslverr"}, 64'(apb_bus.pslverr), 64'd0);
        check({tag, "_wen"},     64'(lb_bus.wen),      64'd0);
        check({tag, "_ren"},     64'(lb_bus.ren),      64'd0);
        check({tag, "_tmo"},     64'(tmo),             64'd0);
        check({tag, "_prdata"},  64'(apb_bus.prdata),  64'd0);
        check({tag, "_waddr"},   64'(lb_bus.waddr),    64'd0);
        check({tag, "_raddr"},   64'(lb_bus.raddr),    64'd0);
        check({tag, "_wdata"},   64'(lb_bus.wdata),    64'd0);
        check({tag, "_wstrb"},   64'(lb_bus.wstrb),    64'd0);
        check({tag, "_state"},   64'(state),           64'(ST_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          base;

    initial begin
        rst             = 1'b1;
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
        apb_bus.paddr   = '0;
        apb_bus.pwdata  = '0;
        apb_bus.pstrb   = '0;
        rsp_en          = 1'b1;
        rsp_dly         = 0;
        late_rvalid     = 1'b0;

        repeat (3) @(negedge clk);
        check_quiet("rst");
        rst = 1'b0;

        // Full write then read back, immediate slave.
        apb_xfer(1'b1, 16'h0, 32'hdead_beef, 4'hf, rd, err, lat);
        check("wr0_lat", 64'(lat), 64'd2);
        check("wr0_err", 64'(err), 64'd0);
        check("wr0_prdata", 64'(rd), 64'd0);
        apb_xfer(1'b0, 16'h0, 32'h0, 4'h0, rd, err, lat);
        check("rd0_data", 64'(rd), 64'hdead_beef);
        check("rd0_err", 64'(err), 64'd0);
        check("rd0_lat", 64'(lat), 64'd2);

        // Partial byte write, back-to-back reads including CNT.
        apb_xfer(1'b1, 16'h0, 32'h6677_8899, 4'b0110, rd, err, lat);
        check("bw_err", 64'(err), 64'd0);
        apb_xfer(1'b0, 16'h0, 32'h0, 4'h0, rd, err, lat);
        check("bw_rd", 64'(rd), 64'hde77_88ef);
        apb_xfer(1'b0, 16'h4, 32'h0, 4'h0, rd, err, lat);
        check("cnt_rd", 64'(rd), 64'h00ff_ff00);
        check("cnt_lat", 64'(lat), 64'd2);

        // Zero-strobe write is forwarded but changes nothing.
        base = wen_cnt;
        apb_xfer(1'b1, 16'h0, 32'hffff_ffff, 4'h0, rd, err, lat);
        check("s0_err", 64'(err), 64'd0);
        check("s0_wen", 64'(wen_cnt - base), 64'd1);
        check("s0_wstrb", 64'(last_wstrb), 64'd0);
        apb_xfer(1'b0, 16'h0, 32'h0, 4'h0, rd, err, lat);
        check("s0_rd", 64'(rd), 64'hde77_88ef);

        // Delayed slave responses.
        rsp_dly = 3;
        apb_xfer(1'b0, 16'h0, 32'h0, 4'h0, rd, err, lat);
        check("d3_lat", 64'(lat), 64'd5);
        check("d3_rd", 64'(rd), 64'hde77_88ef);
        rsp_dly = 7;
        apb_xfer(1'b1, 16'h8, 32'h1, 4'hf, rd, err, lat);
        check("d7_lat", 64'(lat), 64'd9);
        check("d7_err", 64'(err), 64'd0);
        base = tmo_cnt;
        rsp_dly = 8;
        apb_xfer(1'b1, 16'h8, 32'h2, 4'hf, rd, err, lat);
        check("tie_lat", 64'(lat), 64'd10);
        check("tie_err", 64'(err), 64'd0);
        check("tie_tmo", 64'(tmo), 64'd0);
        apb_idle();
        check("tie_tmo_cnt", 64'(tmo_cnt - base), 64'd0);

        // Silent slave: timeout, then a late rvalid must be ignored.
        rsp_en = 1'b0;
        base = tmo_cnt;
        apb_xfer(1'b0, 16'h8, 32'h0, 4'h0, rd, err, lat);
        check("to_lat", 64'(lat), 64'd10);
        check("to_err", 64'(err), 64'd1);
        check("to_prdata", 64'(rd), 64'd0);
        check("to_tmo", 64'(tmo), 64'd1);
        apb_idle();
        check("to_tmo_cnt", 64'(tmo_cnt - base), 64'd1);
        check("to_tmo_drop", 64'(tmo), 64'd0);
        base = pready_cnt;
        late_rvalid = 1'b1;
        repeat (2) @(negedge clk);
        late_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("late_pready", 64'(pready_cnt - base), 64'd0);
        check("late_state", 64'(state), 64'(ST_IDLE));

        // Misaligned accesses: error one cycle after setup, no strobes.
        rsp_en  = 1'b1;
        rsp_dly = 0;
        base = ren_cnt;
        apb_xfer(1'b0, 16'h2, 32'h0, 4'h0, rd, err, lat);
        check("mis_rd_lat", 64'(lat), 64'd1);
        check("mis_rd_err", 64'(err), 64'd1);
        check("mis_rd_prdata", 64'(rd), 64'd0);
        apb_idle();
        check("mis_rd_ren", 64'(ren_cnt - base), 64'd0);
        base = wen_cnt;
        apb_xfer(1'b1, 16'h1, 32'h0, 4'hf, rd, err, lat);
        check("mis_wr_err", 64'(err), 64'd1);
        apb_idle();
        check("mis_wr_wen", 64'(wen_cnt - base), 64'd0);

        // Reset in the cycle after wen aborts the write.
        rsp_dly = 5;
        base = pready_cnt;
        @(negedge clk);
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b1;
        apb_bus.paddr   = 16'h8;
        apb_bus.pwdata  = 32'h1122_3344;
        apb_bus.pstrb   = 4'hf;
        @(negedge clk);
        apb_bus.penable = 1'b1;
        check("ab_wen", 64'(lb_bus.wen), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet("ab");
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("ab_pready", 64'(pready_cnt - base), 64'd0);
        rsp_dly = 0;
        apb_xfer(1'b1, 16'h0, 32'hcafe_f00d, 4'hf, rd, err, lat);
        check("post_wr_lat", 64'(lat), 64'd2);
        check("post_wr_err", 64'(err), 64'd0);
        apb_xfer(1'b0, 16'h0, 32'h0, 4'h0, rd, err, lat);
        check("post_rd", 64'(rd), 64'hcafe_f00d);
        apb_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
